// File: rtl/gbe_rx_frame_fifo.sv
// rtl/gbe_rx_frame_fifo.sv - store-and-forward GbE RX frame buffer with commit/rollback
//
// Purpose: buffers frame bytes from the RX MAC control stage. A frame becomes
// visible to the reader only once it ends cleanly, and an errored frame is
// rolled back by rewinding the write pointer. Committed frames are replayed as a
// valid/ready byte stream with SOP/EOP markers.
//
// Optional feature macro: GBE_RX_FIFO_DROP_CRC_ERR_EN
//   defined   - frames ending with crc_err_i=1 are discarded, rd_err_o stays 0
//   undefined - such frames are delivered with rd_err_o=1 on their last byte
//
// Ports:
//   clk_i, rst_i        single clock, synchronous active-high reset
//   clk_en_i            write-side qualifier for every wr_* input
//   wr_data_i, wr_en_i  frame byte and its valid
//   wr_end_i, wr_err_i  frame end strobe and bad-frame flag
//   crc_err_i           CRC error flag, valid with wr_end_i
//   full_o              no room for another byte or another frame entry
//   rd_data_o, rd_valid_o, rd_sop_o, rd_eop_o, rd_err_o, rd_ready_i
//                       output byte stream towards the packet consumer
//   frames_ok_o, frames_drop_o  wrapping committed/discarded frame counters
module gbe_rx_frame_fifo #(
  parameter int ADDR_W     = 12,
  parameter int LEN_ADDR_W = 5,
  parameter int MIN_LEN    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clk_en_i,
  input  logic [7:0]  wr_data_i,
  input  logic        wr_en_i,
  input  logic        wr_end_i,
  input  logic        wr_err_i,
  input  logic        crc_err_i,
  output logic        full_o,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  output logic        rd_sop_o,
  output logic        rd_eop_o,
  output logic        rd_err_o,
  input  logic        rd_ready_i,
  output logic [15:0] frames_ok_o,
  output logic [15:0] frames_drop_o
);

  localparam logic [ADDR_W:0]     DATA_CAP  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_ADDR_W:0] LQ_CAP    = {1'b1, {LEN_ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]     PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [LEN_ADDR_W:0] LQ_ONE    = (LEN_ADDR_W+1)'(1);
  localparam logic [15:0]         MIN_LEN_W = 16'(MIN_LEN);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  logic [7:0]  mem    [0:(1<<ADDR_W)-1];
  logic [16:0] lq_mem [0:(1<<LEN_ADDR_W)-1];   // {crc_err, frame_len}

  logic [ADDR_W:0]     wr_ptr, commit_ptr, rd_ptr;
  logic [LEN_ADDR_W:0] lq_wr, lq_rd;
  logic [15:0]         frame_len, remaining;
  logic                ovf, frame_err;
  logic [1:0]          state;

  logic [ADDR_W:0] occupancy, wr_ptr_nxt, rd_ptr_inc;
  logic [15:0]     len_nxt;
  logic [16:0]     lq_head;
  logic            lq_full, lq_empty, wr_fire, wr_lost, ovf_nxt;
  logic            end_fire, discard, lq_push, crc_drop, crc_keep;

  assign occupancy = wr_ptr - rd_ptr;
  assign lq_full   = (lq_wr - lq_rd) == LQ_CAP;
  assign lq_empty  = lq_wr == lq_rd;
  assign full_o    = (occupancy == DATA_CAP) || lq_full;

  // A byte arriving in the same cycle as the end strobe belongs to the ending
  // frame, so the end decision works on the post-write pointer/length/ovf.
  assign wr_fire    = clk_en_i & wr_en_i & ~full_o;
  assign wr_lost    = clk_en_i & wr_en_i & full_o;
  assign ovf_nxt    = ovf | wr_lost;
  assign len_nxt    = (wr_fire && frame_len != 16'hFFFF) ? frame_len + 16'd1 : frame_len;
  assign wr_ptr_nxt = wr_fire ? wr_ptr + PTR_ONE : wr_ptr;
  assign end_fire   = clk_en_i & wr_end_i;

`ifdef GBE_RX_FIFO_DROP_CRC_ERR_EN
  assign crc_drop = crc_err_i;
  assign crc_keep = 1'b0;
`else
  assign crc_drop = 1'b0;
  assign crc_keep = crc_err_i;
`endif

  // lq_full only matters for an empty frame when MIN_LEN is 0; otherwise the
  // blocked bytes have already set ovf.
  assign discard = wr_err_i | ovf_nxt | (len_nxt < MIN_LEN_W) | crc_drop | lq_full;
  assign lq_push = end_fire & ~discard;

  assign lq_head    = lq_mem[lq_rd[LEN_ADDR_W-1:0]];
  assign rd_ptr_inc = rd_ptr + PTR_ONE;

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_ptr[ADDR_W-1:0]] <= wr_data_i;
    if (lq_push) lq_mem[lq_wr[LEN_ADDR_W-1:0]] <= {crc_keep, len_nxt};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      frame_len     <= '0;
      ovf           <= 1'b0;
      lq_wr         <= '0;
      frames_ok_o   <= '0;
      frames_drop_o <= '0;
    end else if (end_fire) begin
      frame_len <= '0;
      ovf       <= 1'b0;
      if (discard) begin
        wr_ptr        <= commit_ptr;
        frames_drop_o <= frames_drop_o + 16'd1;
      end else begin
        wr_ptr      <= wr_ptr_nxt;
        commit_ptr  <= wr_ptr_nxt;
        lq_wr       <= lq_wr + LQ_ONE;
        frames_ok_o <= frames_ok_o + 16'd1;
      end
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      frame_len <= len_nxt;
      ovf       <= ovf_nxt;
    end
  end

  // Reader: outputs are registered. While a byte is accepted, the next one is
  // read from rd_ptr+1 in the same cycle so a frame streams without bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      rd_ptr     <= '0;
      lq_rd      <= '0;
      remaining  <= '0;
      frame_err  <= 1'b0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      rd_sop_o   <= 1'b0;
      rd_eop_o   <= 1'b0;
      rd_err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!lq_empty) begin
            lq_rd     <= lq_rd + LQ_ONE;
            frame_err <= lq_head[16];
            remaining <= lq_head[15:0];
            // An empty committed entry (MIN_LEN=0) carries no bytes.
            if (lq_head[15:0] != 16'd0) state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          rd_data_o  <= mem[rd_ptr[ADDR_W-1:0]];
          rd_valid_o <= 1'b1;
          rd_sop_o   <= 1'b1;
          rd_eop_o   <= remaining == 16'd1;
          rd_err_o   <= frame_err & (remaining == 16'd1);
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (rd_ready_i) begin
            rd_ptr <= rd_ptr_inc;
            if (rd_eop_o) begin
              rd_valid_o <= 1'b0;
              rd_sop_o   <= 1'b0;
              rd_eop_o   <= 1'b0;
              rd_err_o   <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              rd_data_o <= mem[rd_ptr_inc[ADDR_W-1:0]];
              remaining <= remaining - 16'd1;
              rd_sop_o  <= 1'b0;
              rd_eop_o  <= remaining == 16'd2;
              rd_err_o  <= frame_err & (remaining == 16'd2);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gbe_rx_frame_fifo.md
Name: gbe_rx_frame_fifo

Overview:
- Store-and-forward frame buffer directly downstream of the GbE RX MAC control stage.
- Accepts the byte stream with its end/err strobes and the CRC error flag; drives back the full flag.
- Only complete, error-free frames are committed. Errored frames are discarded by rolling back the write pointer.
- Committed frames are replayed on a valid/ready byte stream with SOP/EOP to the packet consumer.

Parameters:
ADDR_W, 12, data RAM address width; byte capacity 2**ADDR_W
LEN_ADDR_W, 5, length-queue address width; up to 2**LEN_ADDR_W committed frames queued
MIN_LEN, 1, committed frames shorter than this (bytes) are discarded

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous, active-high reset
clk_en_i  in  1  write-side qualifier; all wr_* inputs sampled only when high
wr_data_i  in  8  frame byte from MAC
wr_en_i  in  1  byte valid
wr_end_i  in  1  frame end strobe, one qualified cycle, after the last byte
wr_err_i  in  1  with wr_end_i: frame bad, discard
crc_err_i  in  1  CRC error flag, valid when wr_end_i is high
full_o  out  1  no room for another byte or another frame entry
rd_data_o  out  8  output byte
rd_valid_o  out  1  output byte valid
rd_sop_o  out  1  first byte of frame
rd_eop_o  out  1  last byte of frame
rd_err_o  out  1  with rd_eop_o: frame had a CRC error
rd_ready_i  in  1  consumer accepts byte
frames_ok_o  out  16  committed-frame counter, wraps
frames_drop_o  out  16  discarded-frame counter, wraps

Behaviour:
- Reset (sync) clears all pointers, the length queue, both counters and the overflow flag.
  - Reset values: rd_valid_o=0, rd_sop_o=0, rd_eop_o=0, rd_err_o=0, rd_data_o=0, full_o=0, frames_ok_o=0, frames_drop_o=0.
  - A partially written frame is lost on reset; a partially read frame is abandoned on reset.
- Write pointers:
  - wr_ptr (speculative) and commit_ptr (committed), both ADDR_W+1 bits; rd_ptr likewise.
  - Occupancy = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- full_o = (occupancy == 2**ADDR_W) || (length queue full); combinational from registers.
- Byte write: on clk_en_i & wr_en_i & !full_o, write RAM[wr_ptr], then wr_ptr+1 and frame_len+1 (16-bit, saturating at 0xFFFF).
- Overflow: wr_en_i while full_o sets ovf; the byte is not stored.
- End handling, on clk_en_i & wr_end_i:
  - Discard when wr_err_i | ovf | frame_len<MIN_LEN (or CRC drop, see feature): wr_ptr<=commit_ptr, frames_drop_o+1.
  - Otherwise commit: push {crc_err_i, frame_len} into the length queue, commit_ptr<=wr_ptr, frames_ok_o+1.
  - In both cases, clear frame_len and ovf.
- Simultaneous wr_en_i and wr_end_i: the byte belongs to the ending frame, and it is written before commit.
- Read FSM:
  - IDLE: leave when the length queue is non-empty; pop the entry, load the remaining count, go to FETCH.
  - FETCH: 1-cycle RAM read, then go to SEND.
  - SEND: present the byte with rd_valid_o=1. rd_sop_o is high on the first byte; rd_eop_o and rd_err_o are high on the byte with remaining==1.
    - On rd_valid_o & rd_ready_i: rd_ptr+1.
    - If eop, return to IDLE; otherwise prefetch the next byte.
  - Prefetch keeps one byte per cycle while rd_ready_i stays high; no bubbles inside a frame.
  - Outputs hold stable while rd_valid_o & !rd_ready_i.
- Latency: the first byte is valid on the 2nd clk_i cycle after the commit cycle.
- The read side ignores clk_en_i.
- The reader never passes commit_ptr, so uncommitted bytes are never exposed.
- Commit and pop in the same cycle are both honoured.
- Length-queue full blocks further bytes via full_o. The MAC then ends the frame with an error and the frame is discarded.

Optional Feature:
- GBE_RX_FIFO_DROP_CRC_ERR_EN defined: a frame ending with crc_err_i=1 is discarded as an errored frame (rollback, frames_drop_o+1); rd_err_o is tied 0.
- Not defined: such frames are committed and delivered with rd_err_o=1 on EOP.

Test Plan:
- Reset, 64-byte good frame 0x00..0x3F, end with err=0, rd_ready_i=1 -> 64 bytes, SOP on 0x00, EOP on 0x3F, rd_err_o=0, frames_ok_o=1, first byte 2 cycles after end.
- 20 bytes, end with err=1, then a 64-byte good frame -> only the 64-byte frame appears; frames_drop_o=1; occupancy back to 0 after reading.
- ADDR_W=6, write a 100-byte frame -> full_o rises at 64 bytes, the end arrives with err, the frame is discarded, full_o drops, no output.
- Good frame with crc_err_i=1 -> macro off: EOP has rd_err_o=1; macro on: no output, frames_drop_o=1.
- Two queued 64-byte frames, rd_ready_i toggling 1/0 each cycle -> all 128 bytes in order, each held stable while not ready, SOP/EOP correct per frame.
- Reset asserted mid-frame on both write and read sides -> all outputs 0 next cycle; a subsequent good frame is delivered intact.
